// File: rtl/mandelbrot_scheduler.sv
// Frame scheduler: walks a WIDTH x HEIGHT frame in raster order, hands pixels to a pool of
// mandelbrot engines and streams their iteration counts out over a valid/ready port.
module mandelbrot_scheduler #(
  parameter int FP_TOP    = 8,
  parameter int FP_BOT    = 24,
  parameter int N_ENGINES = 4,
  parameter int WIDTH     = 640,
  parameter int HEIGHT    = 480
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic [FP_TOP+FP_BOT-1:0]             x_start,
  input  logic [FP_TOP+FP_BOT-1:0]             y_start,
  input  logic [FP_TOP+FP_BOT-1:0]             step,
  input  logic [31:0]                          iterations_max,
  output logic                                 busy,
  output logic                                 done,
  output logic [N_ENGINES-1:0]                 eng_reset,
  output logic [N_ENGINES*(FP_TOP+FP_BOT)-1:0] eng_x0,
  output logic [N_ENGINES*(FP_TOP+FP_BOT)-1:0] eng_y0,
  output logic [31:0]                          eng_iterations_max,
  input  logic [N_ENGINES-1:0]                 eng_finished,
  input  logic [N_ENGINES*32-1:0]              eng_iterations,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [15:0]                          out_x,
  output logic [15:0]                          out_y,
  output logic [31:0]                          out_iterations
);
  localparam int FP = FP_TOP + FP_BOT;
  localparam int IW = (N_ENGINES > 1) ? $clog2(N_ENGINES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;
  state_t state;

  logic [FP-1:0]        x_start_r;
  logic [FP-1:0]        step_r;
  logic [FP-1:0]        cre;
  logic [FP-1:0]        cim;
  logic [15:0]          col;
  logic [15:0]          row;
  logic                 cursor_done;
  logic [N_ENGINES-1:0] eng_busy;
  logic [15:0]          eng_col [N_ENGINES];
  logic [15:0]          eng_row [N_ENGINES];
  logic [IW-1:0]        rr_ptr;

  logic [N_ENGINES-1:0] eligible;
  logic                 out_free;
  logic                 disp_ok;
  logic [IW-1:0]        disp_idx;
  logic                 coll_ok;
  logic [IW-1:0]        coll_idx;
  logic                 fin_ok;

  function automatic logic [IW-1:0] rr_index(input logic [IW-1:0] base, input int k);
    int j;
    j = int'(base) + k;
    if (j >= N_ENGINES) j = j - N_ENGINES;
    return IW'(j);
  endfunction

  // Dispatch picks the lowest idle engine; collect scans round-robin from rr_ptr.
  // An engine being collected is still busy this cycle, so the two never collide.
  always_comb begin
    eligible = eng_busy & eng_finished;
    out_free = !out_valid || out_ready;
    disp_ok  = 1'b0;
    disp_idx = '0;
    for (int i = N_ENGINES - 1; i >= 0; i--) begin
      if (!eng_busy[i]) begin
        disp_ok  = 1'b1;
        disp_idx = IW'(i);
      end
    end
    if (state != S_RUN || cursor_done) disp_ok = 1'b0;
    coll_ok  = 1'b0;
    coll_idx = '0;
    for (int k = N_ENGINES - 1; k >= 0; k--) begin
      if (eligible[rr_index(rr_ptr, k)]) begin
        coll_ok  = 1'b1;
        coll_idx = rr_index(rr_ptr, k);
      end
    end
    if (state != S_RUN || !out_free) coll_ok = 1'b0;
    fin_ok = (state == S_RUN) && cursor_done && (eng_busy == '0) && out_free;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state              <= S_IDLE;
      busy               <= 1'b0;
      done               <= 1'b0;
      x_start_r          <= '0;
      step_r             <= '0;
      cre                <= '0;
      cim                <= '0;
      col                <= '0;
      row                <= '0;
      cursor_done        <= 1'b0;
      eng_busy           <= '0;
      eng_reset          <= '1;
      eng_x0             <= '0;
      eng_y0             <= '0;
      eng_iterations_max <= '0;
      rr_ptr             <= '0;
      out_valid          <= 1'b0;
      out_x              <= '0;
      out_y              <= '0;
      out_iterations     <= '0;
      for (int i = 0; i < N_ENGINES; i++) begin
        eng_col[i] <= '0;
        eng_row[i] <= '0;
      end
    end else begin
      done <= 1'b0;
      if (out_valid && out_ready) out_valid <= 1'b0;

      case (state)
        S_IDLE: begin
          if (start) begin
            state              <= S_RUN;
            busy               <= 1'b1;
            x_start_r          <= x_start;
            step_r             <= step;
            eng_iterations_max <= iterations_max;
            cre                <= x_start;
            cim                <= y_start;
            col                <= '0;
            row                <= '0;
            cursor_done        <= 1'b0;
          end
        end
        S_RUN: begin
          if (fin_ok) begin
            state <= S_FIN;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        S_FIN: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase

      if (disp_ok) begin
        eng_x0[int'(disp_idx)*FP +: FP] <= cre;
        eng_y0[int'(disp_idx)*FP +: FP] <= cim;
        eng_reset[disp_idx]             <= 1'b0;
        eng_busy[disp_idx]              <= 1'b1;
        eng_col[disp_idx]               <= col;
        eng_row[disp_idx]               <= row;
        if (col == 16'(WIDTH - 1)) begin
          col <= '0;
          cre <= x_start_r;
          row <= row + 16'd1;
          cim <= cim + step_r;
          if (row == 16'(HEIGHT - 1)) cursor_done <= 1'b1;
        end else begin
          col <= col + 16'd1;
          cre <= cre + step_r;
        end
      end

      if (coll_ok) begin
        out_valid           <= 1'b1;
        out_x               <= eng_col[coll_idx];
        out_y               <= eng_row[coll_idx];
        out_iterations      <= eng_iterations[int'(coll_idx)*32 +: 32];
        eng_reset[coll_idx] <= 1'b1;
        eng_busy[coll_idx]  <= 1'b0;
        rr_ptr              <= rr_index(coll_idx, 1);
      end
    end
  end

endmodule

// File: tb/tb_mandelbrot_scheduler.sv
// Bench for mandelbrot_scheduler: behavioural engine pool with programmable latency,
// frame-level scoreboard, table-driven frames plus randomized frames.
module tb_mandelbrot_scheduler;
  localparam int N    = 4;
  localparam int W    = 4;
  localparam int H    = 2;
  localparam int FP   = 32;
  localparam int NPIX = W * H;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic [FP-1:0]   x_start, y_start, step;
  logic [31:0]     iterations_max;
  logic            busy, done;
  logic [N-1:0]    eng_reset;
  logic [N*FP-1:0] eng_x0, eng_y0;
  logic [31:0]     eng_iterations_max;
  logic [N-1:0]    eng_finished;
  logic [N*32-1:0] eng_iterations;
  logic            out_valid, out_ready;
  logic [15:0]     out_x, out_y;
  logic [31:0]     out_iterations;

  always #5 clk = ~clk;

  mandelbrot_scheduler #(
    .FP_TOP(8), .FP_BOT(24), .N_ENGINES(N), .WIDTH(W), .HEIGHT(H)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .x_start(x_start), .y_start(y_start), .step(step), .iterations_max(iterations_max),
    .busy(busy), .done(done),
    .eng_reset(eng_reset), .eng_x0(eng_x0), .eng_y0(eng_y0),
    .eng_iterations_max(eng_iterations_max),
    .eng_finished(eng_finished), .eng_iterations(eng_iterations),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_x(out_x), .out_y(out_y), .out_iterations(out_iterations)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] fx, fy, fstep, fitm;
  int lat_lo = 1, lat_hi = 1;
  int disp_cnt = 0, coll_cnt = 0, xfer_cnt = 0, done_cnt = 0, cyc = 0, last_xfer_cyc = -10;
  bit received [NPIX];
  logic [31:0] last_x0, last_y0;

  int eng_cnt [N];
  int eng_lat [N] = '{default: 1};
  int eng_pix [N] = '{default: 0};

  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Engine model: finishes L cycles after leaving reset, result = col + 16*row.
  always @(posedge clk)
    for (int i = 0; i < N; i++)
      eng_cnt[i] <= eng_reset[i] ? 0 : eng_cnt[i] + 1;

  always_comb begin
    eng_finished   = '0;
    eng_iterations = '0;
    for (int i = 0; i < N; i++) begin
      eng_finished[i] = !eng_reset[i] && (eng_cnt[i] >= eng_lat[i]);
      eng_iterations[i*32 +: 32] = eng_finished[i] ?
        32'((eng_pix[i] % W) + 16 * (eng_pix[i] / W)) : 32'hDEADBEEF;
    end
  end

  // Monitor / scoreboard, sampled on the falling edge.
  initial begin : mon
    logic [N-1:0] prev_rst, fall, rise, low;
    logic [15:0]  prev_ox, prev_oy;
    logic [31:0]  prev_oi, ex, ey;
    bit prev_hold, rst_prev, in_rng, ok;
    int e, k, idx;
    prev_rst = '1; prev_hold = 0; rst_prev = 1;
    prev_ox = '0; prev_oy = '0; prev_oi = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_prev) begin
        fall = prev_rst & ~eng_reset;
        rise = ~prev_rst & eng_reset;
        low  = prev_rst & (~prev_rst + N'(1));
        if (fall != '0) begin
          check(fall == low, "disp_lowest_idle", 64'(fall), 64'(low));
          e = 0;
          for (int i = 0; i < N; i++) if (fall[i]) e = i;
          k = disp_cnt;
          check(k < NPIX, "disp_extra", 64'(k), 64'(NPIX));
          if (k < NPIX) begin
            ex = 32'(fx + 32'(k % W) * fstep);
            ey = 32'(fy + 32'(k / W) * fstep);
            check(eng_x0[e*32 +: 32] == ex, "disp_x0", 64'(eng_x0[e*32 +: 32]), 64'(ex));
            check(eng_y0[e*32 +: 32] == ey, "disp_y0", 64'(eng_y0[e*32 +: 32]), 64'(ey));
            if (k == NPIX - 1) begin
              last_x0 = eng_x0[e*32 +: 32];
              last_y0 = eng_y0[e*32 +: 32];
            end
            eng_pix[e] = k;
            eng_lat[e] = int'($urandom_range(lat_hi, lat_lo));
          end
          disp_cnt++;
        end
        if (rise != '0) begin
          check($onehot(rise), "coll_one_per_cycle", 64'(rise), 64'(0));
          check(!prev_hold, "coll_while_stalled", 64'(rise), 64'(0));
          coll_cnt++;
        end
        if (prev_hold)
          check(out_valid && out_x == prev_ox && out_y == prev_oy && out_iterations == prev_oi,
                "hold_stable", {out_x, out_y, out_iterations}, {prev_ox, prev_oy, prev_oi});
        if (out_valid && out_ready) begin
          in_rng = (out_x < W) && (out_y < H);
          idx = in_rng ? int'(out_y) * W + int'(out_x) : 0;
          ok = in_rng && idx < disp_cnt && !received[idx] &&
               out_iterations == 32'(out_x) + 32'(16) * 32'(out_y);
          check(ok, "result", {out_x, out_y, out_iterations}, 64'(idx));
          if (in_rng) received[idx] = 1'b1;
          xfer_cnt++;
          last_xfer_cyc = cyc;
        end
        if (done) begin
          done_cnt++;
          check(!busy && last_xfer_cyc == cyc - 1 && xfer_cnt == NPIX, "done_timing",
                {31'(busy), 1'b0, 32'(xfer_cnt)}, 64'(NPIX));
        end
        if (busy)
          check(eng_iterations_max == fitm, "itmax_latched", 64'(eng_iterations_max), 64'(fitm));
      end
      prev_rst  = eng_reset;
      prev_hold = out_valid && !out_ready;
      prev_ox   = out_x;
      prev_oy   = out_y;
      prev_oi   = out_iterations;
      rst_prev  = reset;
    end
  end

  task automatic check_reset_outputs();
    check(busy == 1'b0, "rst_busy", 64'(busy), 64'(0));
    check(done == 1'b0, "rst_done", 64'(done), 64'(0));
    check(out_valid == 1'b0, "rst_out_valid", 64'(out_valid), 64'(0));
    check(eng_reset == '1, "rst_eng_reset", 64'(eng_reset), 64'(4'hF));
    check(eng_x0 == '0 && eng_y0 == '0, "rst_eng_xy", eng_x0[63:0], 64'(0));
    check(out_x == '0 && out_y == '0 && out_iterations == '0 && eng_iterations_max == '0,
          "rst_out_regs", {out_x, out_y, out_iterations}, 64'(0));
  endtask

  task automatic begin_frame(input logic [31:0] xs, ys, st, itm, input int llo, lhi);
    fx = xs; fy = ys; fstep = st; fitm = itm; lat_lo = llo; lat_hi = lhi;
    disp_cnt = 0; coll_cnt = 0; xfer_cnt = 0; done_cnt = 0; last_xfer_cyc = -10;
    last_x0 = '0; last_y0 = '0;
    for (int i = 0; i < NPIX; i++) received[i] = 1'b0;
    x_start = xs; y_start = ys; step = st; iterations_max = itm; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    x_start = $urandom; y_start = $urandom; step = $urandom; iterations_max = $urandom;
    check(busy == 1'b1, "start_busy", 64'(busy), 64'(1));
  endtask

  task automatic run_frame(input logic [31:0] xs, ys, st, itm,
                           input int llo, lhi, rpct, stall_at, restart_at);
    int c = 0;
    int snap = 0;
    begin_frame(xs, ys, st, itm, llo, lhi);
    while (done_cnt == 0 && c < 2000) begin
      if (stall_at >= 0 && c >= stall_at && c < stall_at + 20) out_ready = 1'b0;
      else out_ready = ($urandom_range(99) < rpct);
      if (stall_at >= 0 && c == stall_at + 20) snap = xfer_cnt;
      if (stall_at >= 0 && c == stall_at + 24)
        check(xfer_cnt - snap == 4, "back_to_back", 64'(xfer_cnt - snap), 64'(4));
      start = (c == restart_at);
      @(posedge clk); #1;
      c++;
    end
    start = 1'b0;
    out_ready = 1'b1;
    check(done_cnt == 1, "frame_end", 64'(done_cnt), 64'(1));
    repeat (4) @(posedge clk);
    #1;
    check(done_cnt == 1 && !busy && xfer_cnt == NPIX, "frame_tail",
          {32'(done_cnt), 32'(xfer_cnt)}, {32'(1), 32'(NPIX)});
  endtask

  typedef struct {
    logic [31:0] xs, ys, st;
    int          lat, rpct, stall_at, restart_at;
    logic [31:0] exp_x0, exp_y0;
  } vec_t;

  vec_t vt [6];

  initial begin
    vt[0] = '{32'hFE000000, 32'hFF000000, 32'h00100000, 3, 100, -1, -1, 32'hFE300000, 32'hFF100000};
    vt[1] = '{32'h00000000, 32'h00000000, 32'h01000000, 1, 100, -1, -1, 32'h03000000, 32'h01000000};
    vt[2] = '{32'h7F000000, 32'h7F000000, 32'h01000000, 2,  60, -1, -1, 32'h82000000, 32'h80000000};
    vt[3] = '{32'h00000000, 32'h00000000, 32'hFFF00000, 10, 100, -1, -1, 32'hFFD00000, 32'hFFF00000};
    vt[4] = '{32'hFE000000, 32'hFF000000, 32'h00100000, 3, 100,  3, -1, 32'hFE300000, 32'hFF100000};
    vt[5] = '{32'h00000000, 32'h00000000, 32'h00010000, 4,  80, -1,  2, 32'h00030000, 32'h00010000};

    reset = 1'b1; start = 1'b0; out_ready = 1'b1;
    x_start = '0; y_start = '0; step = '0; iterations_max = '0;
    fx = '0; fy = '0; fstep = '0; fitm = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    foreach (vt[i]) begin
      run_frame(vt[i].xs, vt[i].ys, vt[i].st, 32'd100 + 32'(i), vt[i].lat, vt[i].lat,
                vt[i].rpct, vt[i].stall_at, vt[i].restart_at);
      check(last_x0 == vt[i].exp_x0 && last_y0 == vt[i].exp_y0, "last_pixel_coord",
            {last_x0, last_y0}, {vt[i].exp_x0, vt[i].exp_y0});
    end

    // Reset in the middle of a frame, then a clean frame.
    begin_frame(32'h0, 32'h0, 32'h00100000, 32'd50, 3, 3);
    out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_reset_outputs();
    repeat (2) @(posedge clk);
    #1;
    run_frame(32'hFE000000, 32'hFF000000, 32'h00100000, 32'd77, 3, 3, 100, -1, -1);

    for (int f = 0; f < 20; f++) begin
      int llo;
      llo = int'($urandom_range(4, 1));
      run_frame($urandom, $urandom, $urandom, $urandom, llo, llo + int'($urandom_range(8, 0)),
                int'($urandom_range(100, 30)), -1, (f % 4 == 0) ? 3 : -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
